// File: rtl/pps_div_pkg.sv
// Shared types and defaults for the multi-channel PPS divider.
// The holdover flywheel is enabled by defining PPS_DIV_MULTI_HOLDOVER_EN.
package pps_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PHASE = 2'd2,
    HIGH  = 2'd3
  } ch_state_e;

  localparam int SYNC_DEPTH = 2;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_DIV_W       = 8;
  localparam int DEF_PHASE_W     = 32;
  localparam int DEF_WIDTH_W     = 32;
  localparam int DEF_CLK_PER_SEC = 10_000_000;
  localparam int DEF_HOLD_TOL    = 1000;

endpackage

// File: rtl/pps_div_channel.sv
// One divider channel: tick counting, phase delay and pulse width FSM.
module pps_div_channel
  import pps_div_pkg::*;
#(
  parameter int DIV_W   = DEF_DIV_W,
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int WIDTH_W = DEF_WIDTH_W
) (
  input  logic               i_clk_10,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic [DIV_W-1:0]   i_div_num,
  input  logic [PHASE_W-1:0] i_phase,
  input  logic [WIDTH_W-1:0] i_width,
  input  logic               i_per_true,
  input  logic               i_start,
  input  logic               i_stop,
  output logic               o_pps_divided,
  output logic               o_busy,
  output logic               o_overrun
);

  localparam int CNT_W = (PHASE_W > WIDTH_W) ? PHASE_W : WIDTH_W;

  ch_state_e          r_state;
  ch_state_e          w_next;
  ch_state_e          w_after_high;
  logic [DIV_W-1:0]   r_div;
  logic [DIV_W-1:0]   r_tick_cnt;
  logic [PHASE_W-1:0] r_phase;
  logic [WIDTH_W-1:0] r_width;
  logic               r_per;
  logic               r_overrun;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_start_ok;
  logic               w_qual;
  logic               w_has_phase;
  logic               w_has_width;
  logic               w_phase_done;
  logic               w_width_done;

  assign w_start_ok   = i_start & ~i_stop & (r_state == IDLE);
  assign w_qual       = i_tick & (r_tick_cnt == (r_div - DIV_W'(1)));
  assign w_has_phase  = (r_phase != '0);
  assign w_has_width  = (r_width != '0);
  // Counters are compared against value-1 so an all-ones setting never wraps.
  assign w_phase_done = (r_cnt == (CNT_W'(r_phase) - CNT_W'(1)));
  assign w_width_done = (r_cnt == (CNT_W'(r_width) - CNT_W'(1)));
  assign w_after_high = r_per ? ARMED : IDLE;

  always_ff @(posedge i_clk_10 or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_start_ok) w_next = ARMED;
      ARMED: begin
        if (w_qual) begin
          if (w_has_phase)      w_next = PHASE;
          else if (w_has_width) w_next = HIGH;
          else                  w_next = w_after_high;
        end
      end
      PHASE: if (w_phase_done) w_next = w_has_width ? HIGH : w_after_high;
      HIGH:  if (w_width_done) w_next = w_after_high;
      default: w_next = IDLE;
    endcase
    if (i_stop) w_next = IDLE;
  end

  always_comb begin
    o_pps_divided = (r_state == HIGH);
    o_busy        = (r_state != IDLE);
    o_overrun     = r_overrun;
  end

  // Shadow settings, tick counter and the shared phase/width cycle counter.
  always_ff @(posedge i_clk_10 or negedge i_rst) begin
    if (!i_rst) begin
      r_div      <= '0;
      r_phase    <= '0;
      r_width    <= '0;
      r_per      <= 1'b0;
      r_tick_cnt <= '0;
      r_overrun  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_start_ok) begin
        r_div      <= (i_div_num == '0) ? DIV_W'(1) : i_div_num;
        r_phase    <= i_phase;
        r_width    <= i_width;
        r_per      <= i_per_true;
        r_tick_cnt <= '0;
        r_overrun  <= 1'b0;
      end else begin
        if ((r_state != IDLE) && i_tick)
          r_tick_cnt <= w_qual ? '0 : r_tick_cnt + DIV_W'(1);
        if (w_qual && ((r_state == PHASE) || (r_state == HIGH)))
          r_overrun <= 1'b1;
      end
      r_cnt <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pps_div_multi.sv
// Multi-channel PPS divider: PPS synchroniser, edge detect and optional
// holdover flywheel (PPS_DIV_MULTI_HOLDOVER_EN), feeding N_CH channels.
module pps_div_multi
  import pps_div_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int PHASE_W     = DEF_PHASE_W,
  parameter int WIDTH_W     = DEF_WIDTH_W,
  parameter int CLK_PER_SEC = DEF_CLK_PER_SEC,
  parameter int HOLD_TOL    = DEF_HOLD_TOL
) (
  input  logic                    i_clk_10,
  input  logic                    i_rst,
  input  logic                    i_pps_raw,
  input  logic [N_CH*DIV_W-1:0]   i_div_num,
  input  logic [N_CH*PHASE_W-1:0] i_phase,
  input  logic [N_CH*WIDTH_W-1:0] i_width,
  input  logic [N_CH-1:0]         i_per_true,
  input  logic [N_CH-1:0]         i_start,
  input  logic [N_CH-1:0]         i_stop,
  output logic [N_CH-1:0]         o_pps_divided,
  output logic [N_CH-1:0]         o_busy,
  output logic [N_CH-1:0]         o_overrun,
  output logic                    o_pps_tick,
  output logic                    o_holdover
);

  logic [SYNC_DEPTH-1:0] r_sync;
  logic                  r_pps_d;
  logic                  r_pps_tick;
  logic                  w_rise;
  logic                  w_tick;

  assign w_rise = r_sync[SYNC_DEPTH-1] & ~r_pps_d;

  always_ff @(posedge i_clk_10 or negedge i_rst) begin
    if (!i_rst) begin
      r_sync     <= '0;
      r_pps_d    <= 1'b0;
      r_pps_tick <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_DEPTH-2:0], i_pps_raw};
      r_pps_d    <= r_sync[SYNC_DEPTH-1];
      r_pps_tick <= w_rise;
    end
  end

  assign o_pps_tick = r_pps_tick;

`ifdef PPS_DIV_MULTI_HOLDOVER_EN
  localparam int LIMIT  = CLK_PER_SEC + HOLD_TOL;
  localparam int FREE_W = $clog2(LIMIT + 1);

  logic [FREE_W-1:0] r_free;
  logic              r_hold;
  logic              r_syn_tick;
  logic              w_expire;

  // First expiry waits the full tolerance; later ones follow the nominal period.
  assign w_expire = (r_free == (r_hold ? FREE_W'(CLK_PER_SEC - 1) : FREE_W'(LIMIT - 1)));

  always_ff @(posedge i_clk_10 or negedge i_rst) begin
    if (!i_rst) begin
      r_free     <= '0;
      r_hold     <= 1'b0;
      r_syn_tick <= 1'b0;
    end else if (w_rise) begin
      r_free     <= '0;
      r_hold     <= 1'b0;
      r_syn_tick <= 1'b0;
    end else if (w_expire) begin
      r_free     <= '0;
      r_hold     <= 1'b1;
      r_syn_tick <= 1'b1;
    end else begin
      r_free     <= r_free + FREE_W'(1);
      r_syn_tick <= 1'b0;
    end
  end

  assign w_tick     = r_pps_tick | r_syn_tick;
  assign o_holdover = r_hold;
`else
  assign w_tick     = r_pps_tick;
  assign o_holdover = 1'b0;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pps_div_channel #(
      .DIV_W  (DIV_W),
      .PHASE_W(PHASE_W),
      .WIDTH_W(WIDTH_W)
    ) u_ch (
      .i_clk_10     (i_clk_10),
      .i_rst        (i_rst),
      .i_tick       (w_tick),
      .i_div_num    (i_div_num[g*DIV_W +: DIV_W]),
      .i_phase      (i_phase[g*PHASE_W +: PHASE_W]),
      .i_width      (i_width[g*WIDTH_W +: WIDTH_W]),
      .i_per_true   (i_per_true[g]),
      .i_start      (i_start[g]),
      .i_stop       (i_stop[g]),
      .o_pps_divided(o_pps_divided[g]),
      .o_busy       (o_busy[g]),
      .o_overrun    (o_overrun[g])
    );
  end

endmodule
